// File: rtl/data_mem_responder.sv
// Load/store memory target with a valid/ready request port and a fixed, parameterised
// number of wait states between acceptance and the memory access.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q, rdata_nxt;
    logic                  err_q, err_nxt;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           word, ld_data, st_data, st_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [3:0]            be;
    logic                  acc_err, accept, commit, mem_we;

    // Bits above the word index are deliberately ignored so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Access decode from the captured request.
    always_comb begin
        widx    = addr_q[ADDR_WIDTH+1:2];
        word    = mem[widx];
        ld_byte = 8'(word >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? word[31:16] : word[15:0];
        acc_err = 1'b0;
        ld_data = '0;
        be      = '0;
        st_data = wdata_q;
        if (!we_q) begin
            case (f3_q)
                3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
                3'b001: begin
                    acc_err = addr_q[0];
                    ld_data = {{16{ld_half[15]}}, ld_half};
                end
                3'b010: begin
                    acc_err = |addr_q[1:0];
                    ld_data = word;
                end
                3'b100: ld_data = {24'b0, ld_byte};
                3'b101: begin
                    acc_err = addr_q[0];
                    ld_data = {16'b0, ld_half};
                end
                default: acc_err = 1'b1;
            endcase
        end else begin
            case (f3_q)
                3'b000: begin
                    be      = 4'b0001 << addr_q[1:0];
                    st_data = {4{wdata_q[7:0]}};
                end
                3'b001: begin
                    acc_err = addr_q[0];
                    be      = addr_q[1] ? 4'b1100 : 4'b0011;
                    st_data = {2{wdata_q[15:0]}};
                end
                3'b010: begin
                    acc_err = |addr_q[1:0];
                    be      = 4'b1111;
                end
                default: acc_err = 1'b1;
            endcase
        end
        for (int unsigned i = 0; i < 4; i++) begin
            st_word[8*i +: 8] = be[i] ? st_data[8*i +: 8] : word[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                    err_nxt   = acc_err;
                    rdata_nxt = (we_q || acc_err) ? '0 : ld_data;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_we = commit && we_q && !acc_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[ADDR_WIDTH+1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    // Storage is not reset; an aborted store never reaches this enable.
    always_ff @(posedge clk) begin
        if (mem_we) mem[widx] <= st_word;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of load/store vectors plus
// hand-written stall, reset-abort and zero-latency sequences.
`timescale 1ns/1ps
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid_z, req_ready_z, req_we_z;
    logic [2:0]  req_funct3_z;
    logic [31:0] req_addr_z, req_wdata_z;
    logic        rsp_valid_z, rsp_ready_z, rsp_err_z, busy_z;
    logic [31:0] rsp_rdata_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_funct3(req_funct3_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
        .rsp_err(rsp_err_z), .busy(busy_z)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one request on the LATENCY=2 instance; lat counts edges from acceptance
    // to the first edge after which rsp_valid is seen high.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output logic still_valid);
        int k;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = '1; req_wdata = '1;
        k = 0;
        while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
        lat = k;
        rd  = rsp_rdata;
        er  = rsp_err;
        @(negedge clk);
        still_valid = rsp_valid;
    endtask

    task automatic txn_z(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat);
        int k;
        @(negedge clk);
        req_valid_z = 1'b1; req_we_z = we; req_funct3_z = f3; req_addr_z = addr; req_wdata_z = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid_z = 1'b0;
        k = 0;
        while (!rsp_valid_z && k < 40) begin @(negedge clk); k++; end
        lat = k;
        rd  = rsp_rdata_z;
        er  = rsp_err_z;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er, sv;
        int          lat, k;

        //          we    f3      addr        wdata         rdata         err
        vt.push_back('{1'b1, 3'b010, 32'h28,   32'h00000640, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h28,   32'h0,        32'h00000640, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h40,   32'h80FF7F01, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 3'b000, 32'h43,   32'h0,        32'hFFFFFF80, 1'b0});
        vt.push_back('{1'b0, 3'b100, 32'h43,   32'h0,        32'h00000080, 1'b0});
        vt.push_back('{1'b0, 3'b000, 32'h41,   32'h0,        32'h0000007F, 1'b0});
        vt.push_back('{1'b0, 3'b000, 32'h42,   32'h0,        32'hFFFFFFFF, 1'b0});
        vt.push_back('{1'b0, 3'b001, 32'h42,   32'h0,        32'hFFFF80FF, 1'b0});
        vt.push_back('{1'b0, 3'b101, 32'h42,   32'h0,        32'h000080FF, 1'b0});
        vt.push_back('{1'b0, 3'b001, 32'h40,   32'h0,        32'h00007F01, 1'b0});
        vt.push_back('{1'b0, 3'b100, 32'h40,   32'h0,        32'h00000001, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h40,   32'h11223344, 32'h00000000, 1'b0});
        vt.push_back('{1'b1, 3'b000, 32'h41,   32'hFFFFFFAB, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'h1122AB44, 1'b0});
        vt.push_back('{1'b1, 3'b001, 32'h42,   32'h1234BEEF, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h40,   32'h0,        32'hBEEFAB44, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h2A,   32'h0,        32'h00000000, 1'b1});
        vt.push_back('{1'b1, 3'b010, 32'h44,   32'hCAFEF00D, 32'h00000000, 1'b0});
        vt.push_back('{1'b1, 3'b001, 32'h45,   32'h00001234, 32'h00000000, 1'b1});
        vt.push_back('{1'b1, 3'b010, 32'h46,   32'h99999999, 32'h00000000, 1'b1});
        vt.push_back('{1'b1, 3'b011, 32'h44,   32'h77777777, 32'h00000000, 1'b1});
        vt.push_back('{1'b0, 3'b011, 32'h44,   32'h0,        32'h00000000, 1'b1});
        vt.push_back('{1'b0, 3'b110, 32'h44,   32'h0,        32'h00000000, 1'b1});
        vt.push_back('{1'b0, 3'b010, 32'h44,   32'h0,        32'hCAFEF00D, 1'b0});
        vt.push_back('{1'b0, 3'b101, 32'h46,   32'h0,        32'h0000CAFE, 1'b0});
        vt.push_back('{1'b0, 3'b001, 32'h46,   32'h0,        32'hFFFFCAFE, 1'b0});
        vt.push_back('{1'b1, 3'b000, 32'h47,   32'h0000005A, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h44,   32'h0,        32'h5AFEF00D, 1'b0});
        vt.push_back('{1'b1, 3'b010, 32'h1050, 32'h12345678, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 3'b010, 32'h50,   32'h0,        32'h12345678, 1'b0});

        reset = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_funct3_z = '0; req_addr_z = '0; req_wdata_z = '0;
        rsp_ready_z = 1'b1;

        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst rsp_err",   32'(rsp_err), 32'd0);
        check("rst busy",      32'(busy), 32'd0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post-rst req_ready", 32'(req_ready), 32'd1);
        check("post-rst busy", 32'(busy), 32'd0);

        for (int i = 0; i < vt.size(); i++) begin
            txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat, sv);
            check($sformatf("v%0d rdata", i), rd, vt[i].rdata);
            check($sformatf("v%0d err", i), 32'(er), 32'(vt[i].err));
            check($sformatf("v%0d latency", i), 32'(lat), 32'd3);
            check($sformatf("v%0d one-cycle valid", i), 32'(sv), 32'd0);
        end

        // Initiator stall: response must hold, and a pending request must not be taken.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h0; req_funct3 = 3'b010;
        k = 0;
        while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
        check("stall latency", 32'(k), 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("stall%0d rsp_rdata", c), rsp_rdata, 32'hBEEFAB44);
            check($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall release rsp_valid", 32'(rsp_valid), 32'd0);
        check("stall release busy", 32'(busy), 32'd0);
        txn(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat, sv);
        check("stall no store", rd, 32'hBEEFAB44);

        // Reset during WAIT of a store: store dropped, no response afterwards.
        txn(1'b1, 3'b010, 32'h10, 32'h01020304, rd, er, lat, sv);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort busy before rst", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd0);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sv = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sv = sv | rsp_valid;
        end
        check("abort spurious rsp_valid", 32'(sv), 32'd0);
        txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, sv);
        check("abort prior value", rd, 32'h01020304);
        check("abort load err", 32'(er), 32'd0);

        // Zero-latency instance.
        txn_z(1'b1, 3'b010, 32'h8, 32'h0BADF00D, rd, er, lat);
        check("lat0 store latency", 32'(lat), 32'd1);
        check("lat0 store rdata", rd, 32'd0);
        txn_z(1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
        check("lat0 load latency", 32'(lat), 32'd1);
        check("lat0 load rdata", rd, 32'h0BADF00D);
        txn_z(1'b0, 3'b001, 32'h9, 32'h0, rd, er, lat);
        check("lat0 misaligned err", 32'(er), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
